conv_channel_accumulator: RTL and testbench

CONV_CHANNEL_ACCUMULATOR -- requirements
Module: conv_channel_accumulator

---
 rtl/conv_channel_accumulator.sv | 149 ++++++++++++++
 tb/tb_conv_channel_accumulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_channel_accumulator.sv
// Sums CHANNEL_NUM_IN partial-sum planes plus a bias into saturated output pixels.
// Optional build macro CONV_ACC_RELU_EN clamps negative results to zero.
module conv_channel_accumulator #(
    parameter int DATA_WIDTH      = 32,
    parameter int OUT_SIZE        = 256,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  done
);

    localparam int PW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int CW = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
    localparam int OW = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

    localparam logic [PW-1:0] PXL_LAST = PW'(OUT_SIZE - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(CHANNEL_NUM_IN - 1);
    localparam logic [OW-1:0] OCH_LAST = OW'(CHANNEL_NUM_OUT - 1);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ACC_FIRST,
        ACC_MID,
        ACC_LAST,
        ACC_SINGLE
    } acc_state_t;

    logic [PW-1:0]         pxl_cnt;
    logic [PW-1:0]         pxl_cnt_next;
    logic [CW-1:0]         ch_cnt;
    logic [CW-1:0]         ch_cnt_next;
    logic [OW-1:0]         och_cnt;
    logic [OW-1:0]         och_cnt_next;
    acc_state_t            state;
    logic [DATA_WIDTH-1:0] bias_reg;
    logic [DATA_WIDTH-1:0] ram [OUT_SIZE];
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] result;
    logic                  ram_we;
    logic                  emit;
    logic                  last_of_run;

    // Overflow shows up as a mismatch between the extended sign bit and the MSB.
    function automatic logic [DATA_WIDTH-1:0] sat_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            return s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
        return s[DATA_WIDTH-1:0];
    endfunction

    // The counter triple is the state register; the accumulation phase decodes from ch_cnt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxl_cnt <= '0;
            ch_cnt  <= '0;
            och_cnt <= '0;
        end else begin
            pxl_cnt <= pxl_cnt_next;
            ch_cnt  <= ch_cnt_next;
            och_cnt <= och_cnt_next;
        end
    end

    always_comb begin
        pxl_cnt_next = pxl_cnt;
        ch_cnt_next  = ch_cnt;
        och_cnt_next = och_cnt;
        if (valid_in) begin
            if (pxl_cnt == PXL_LAST) begin
                pxl_cnt_next = '0;
                if (ch_cnt == CH_LAST) begin
                    ch_cnt_next  = '0;
                    och_cnt_next = (och_cnt == OCH_LAST) ? '0 : och_cnt + 1'b1;
                end else begin
                    ch_cnt_next = ch_cnt + 1'b1;
                end
            end else begin
                pxl_cnt_next = pxl_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        if (CHANNEL_NUM_IN == 1) begin
            state = ACC_SINGLE;
        end else if (ch_cnt == '0) begin
            state = ACC_FIRST;
        end else if (ch_cnt == CH_LAST) begin
            state = ACC_LAST;
        end else begin
            state = ACC_MID;
        end
    end

    // Read-modify-write completes within one cycle, so consecutive addresses never collide.
    always_comb begin
        base        = (state == ACC_FIRST || state == ACC_SINGLE) ? bias_reg : ram[pxl_cnt];
        sum         = sat_add(base, pxl_in);
        ram_we      = valid_in && (state == ACC_FIRST || state == ACC_MID);
        emit        = valid_in && (state == ACC_LAST || state == ACC_SINGLE);
        last_of_run = emit && (pxl_cnt == PXL_LAST) && (och_cnt == OCH_LAST);
`ifdef CONV_ACC_RELU_EN
        result      = sum[DATA_WIDTH-1] ? '0 : sum;
`else
        result      = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[pxl_cnt] <= sum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bias_reg  <= '0;
            pxl_out   <= '0;
            valid_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= emit;
            done      <= last_of_run;
            if (emit) begin
                pxl_out <= result;
            end
            if (valid_bias_in) begin
                bias_reg <= bias_in;
            end
        end
    end

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Scoreboard bench for conv_channel_accumulator; honours CONV_ACC_RELU_EN when defined.
module tb_conv_channel_accumulator;

    localparam int DW    = 32;
    localparam int OUT   = 4;
    localparam int CIN   = 3;
    localparam int COUT  = 2;
    localparam int TOTAL = OUT * CIN * COUT;

    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] pxl_in = '0;
    logic          valid_bias_in = 1'b0;
    logic [DW-1:0] bias_in = '0;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic          done;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        int            cyc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    longint model_acc[OUT];
    longint model_bias = 0;
    int     model_n = 0;
    logic [DW-1:0] last_out = '0;

    conv_channel_accumulator #(
        .DATA_WIDTH(DW),
        .OUT_SIZE(OUT),
        .CHANNEL_NUM_IN(CIN),
        .CHANNEL_NUM_OUT(COUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .pxl_in(pxl_in),
        .valid_bias_in(valid_bias_in),
        .bias_in(bias_in),
        .pxl_out(pxl_out),
        .valid_out(valid_out),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sat(input longint s);
        if (s > MAXV) return MAXV;
        if (s < MINV) return MINV;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Input n of a run belongs to pixel n%OUT of input plane (n/OUT)%CIN.
    task automatic modelAccept(input logic [DW-1:0] d);
        int     p;
        int     ch;
        int     och;
        longint s;
        exp_t   e;
        p   = model_n % OUT;
        ch  = (model_n / OUT) % CIN;
        och = model_n / (OUT * CIN);
        s   = sat(((ch == 0) ? model_bias : model_acc[p]) + longint'($signed(d)));
        if (ch == CIN - 1) begin
`ifdef CONV_ACC_RELU_EN
            if (s < 0) s = 0;
`endif
            e.data = s[DW-1:0];
            e.last = (p == OUT - 1) && (och == COUT - 1);
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end else begin
            model_acc[p] = s;
        end
        model_n = (model_n + 1) % TOTAL;
    endtask

    task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit bv, input logic [DW-1:0] b);
        valid_in      = v;
        pxl_in        = d;
        valid_bias_in = bv;
        bias_in       = b;
        if (v) modelAccept(d);
        if (bv) model_bias = longint'($signed(b));
        @(posedge clk);
        #1;
        valid_in      = 1'b0;
        valid_bias_in = 1'b0;
    endtask

    task automatic doReset(input int n);
        applyStimulus(0, '0, 0, '0);
        applyStimulus(0, '0, 0, '0);
        checkOutput("queue_empty_at_reset", exp_q.size(), 0);
        reset      = 1'b0;
        model_n    = 0;
        model_bias = 0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever valid_out is seen and checks holds otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("reset_pxl_out", pxl_out, '0);
            checkOutput("reset_valid_out", valid_out, '0);
            checkOutput("reset_done", done, '0);
            last_out = '0;
        end else if (valid_out) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_valid_out: got pxl_out 0x%08h, expected no output at cycle %0d", pxl_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("pxl_out", pxl_out, mon_e.data);
                checkOutput("done", done, mon_e.last);
                checkOutput("latency_cycle", cyc, mon_e.cyc);
            end
            last_out = pxl_out;
        end else begin
            checkOutput("pxl_out_hold", pxl_out, last_out);
            checkOutput("done_idle", done, '0);
        end
    end

    initial begin
        logic [DW-1:0] d;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // All ones with bias 5: every output is 8, done with the eighth.
        applyStimulus(0, '0, 1, 32'd5);
        repeat (TOTAL) applyStimulus(1, 32'd1, 0, '0);

        // Positive saturation.
        applyStimulus(0, '0, 1, 32'h10);
        repeat (TOTAL) applyStimulus(1, 32'h7FFFFFF0, 0, '0);

        // Negative result, clamped only with the ReLU build.
        applyStimulus(0, '0, 1, '0);
        repeat (TOTAL) applyStimulus(1, 32'hFFFFFFFE, 0, '0);

        // Ramp data with random bubbles carrying junk data.
        applyStimulus(0, '0, 1, $urandom_range(0, 100));
        for (int i = 0; i < TOTAL; i++) begin
            repeat ($urandom_range(0, 3)) applyStimulus(0, $urandom, 0, '0);
            applyStimulus(1, ((i / OUT) % CIN) * 10 + i % OUT, 0, '0);
        end

        // Reset mid-run, then a clean run.
        applyStimulus(0, '0, 1, 32'd7);
        repeat (5) applyStimulus(1, 32'd1, 0, '0);
        doReset(2);
        applyStimulus(0, '0, 1, 32'd5);
        repeat (TOTAL) applyStimulus(1, 32'd1, 0, '0);

        // Bias load coincident with first input of output channel 1, then reload before next run.
        applyStimulus(0, '0, 1, 32'd5);
        repeat (OUT * CIN) applyStimulus(1, $urandom_range(0, 50), 0, '0);
        applyStimulus(1, $urandom_range(0, 50), 1, 32'd9);
        repeat (OUT * CIN - 1) applyStimulus(1, $urandom_range(0, 50), 0, '0);
        applyStimulus(0, '0, 1, 32'd9);
        repeat (TOTAL) applyStimulus(1, $urandom_range(0, 50), 0, '0);

        // Random full-range data, bubbles and bias loads.
        for (int i = 0; i < TOTAL * 3; i++) begin
            repeat ($urandom_range(0, 2)) applyStimulus(0, $urandom, ($urandom_range(0, 7) == 0), $urandom);
            case ($urandom_range(0, 3))
                0: d = 32'h7FFFFF00 | ($urandom & 32'hFF);
                1: d = 32'h80000000 | ($urandom & 32'hFF);
                default: d = $urandom;
            endcase
            applyStimulus(1, d, ($urandom_range(0, 7) == 0), $urandom);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
